// File: rtl/colab_pkg.sv
// Shared pipeline package: default widths, the x0 index constant and common word/index types.
package colab_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/wb_reg_file_if.sv
// MEM/WB-to-register-file bus: write-back inputs, ID read indices and the returned data/count.
interface wb_reg_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
);

  logic              MemtoReg_i;
  logic              RegWrite_i;
  logic [DATA_W-1:0] mem_data_i;
  logic [DATA_W-1:0] alu_result_i;
  logic [ADDR_W-1:0] RDaddr_i;
  logic [ADDR_W-1:0] RSaddr_i;
  logic [ADDR_W-1:0] RTaddr_i;
  logic [DATA_W-1:0] RSdata_o;
  logic [DATA_W-1:0] RTdata_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [CNT_W-1:0]  wb_cnt_o;

  modport master (
    output MemtoReg_i, RegWrite_i, mem_data_i, alu_result_i, RDaddr_i, RSaddr_i, RTaddr_i,
    input  RSdata_o, RTdata_o, wb_data_o, wb_cnt_o
  );

  modport slave (
    input  MemtoReg_i, RegWrite_i, mem_data_i, alu_result_i, RDaddr_i, RSaddr_i, RTaddr_i,
    output RSdata_o, RTdata_o, wb_data_o, wb_cnt_o
  );

endinterface

// File: rtl/rf_read_port.sv
// One asynchronous register-file read port with reset / x0 / bypass / array priority.
module rf_read_port
  import colab_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic              byp_valid,
  input  logic [ADDR_W-1:0] byp_idx,
  input  logic [DATA_W-1:0] byp_data,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    rdata = '0;
    if (!rst_i) begin
      rdata = '0;
    end else if (idx == ADDR_W'(REG_ZERO)) begin
      rdata = '0;
    end else if (byp_valid && (idx == byp_idx)) begin
      rdata = byp_data;
    end else begin
      rdata = regs[idx];
    end
  end

endmodule

// File: rtl/wb_reg_file.sv
// Write-back mux, architectural register file and committed-write counter.
// Define WB_RF_BYPASS_EN to forward the in-flight write to same-cycle reads.
module wb_reg_file
  import colab_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = 32
) (
  input logic         clk_i,
  input logic         rst_i,
  wb_reg_file_if.slave bus
);

  localparam int unsigned NumRegs = 2**ADDR_W;

  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en;
  logic              byp_valid;

  assign wb_data       = bus.MemtoReg_i ? bus.mem_data_i : bus.alu_result_i;
  assign bus.wb_data_o = wb_data;
  assign bus.wb_cnt_o  = cnt_q;

  // x0 writes are dropped here, so they neither land in the array nor count.
  assign wr_en = bus.RegWrite_i && (bus.RDaddr_i != ADDR_W'(REG_ZERO));

`ifdef WB_RF_BYPASS_EN
  assign byp_valid = wr_en;
`else
  assign byp_valid = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[bus.RDaddr_i] <= wb_data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rs_port (
    .rst_i     (rst_i),
    .idx       (bus.RSaddr_i),
    .regs      (regs_q),
    .byp_valid (byp_valid),
    .byp_idx   (bus.RDaddr_i),
    .byp_data  (wb_data),
    .rdata     (bus.RSdata_o)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rt_port (
    .rst_i     (rst_i),
    .idx       (bus.RTaddr_i),
    .regs      (regs_q),
    .byp_valid (byp_valid),
    .byp_idx   (bus.RDaddr_i),
    .byp_data  (wb_data),
    .rdata     (bus.RTdata_o)
  );

endmodule

// File: tb/tb_wb_reg_file.sv
// Scoreboard bench for wb_reg_file: directed scenarios plus a random stream against a spec model.
module tb_wb_reg_file;

  localparam int unsigned CntW = 4;

  localparam int unsigned SelRs  = 0;
  localparam int unsigned SelRt  = 1;
  localparam int unsigned SelWb  = 2;
  localparam int unsigned SelCnt = 3;

`ifdef WB_RF_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  wb_reg_file_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(CntW)) bus ();

  wb_reg_file #(
    .DATA_W (32),
    .ADDR_W (5),
    .CNT_W  (CntW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state derived from the behavioural description.
  logic [31:0]     m_rf [32];
  logic [CntW-1:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int unsigned sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SelRs:   obs = bus.RSdata_o;
        SelRt:   obs = bus.RTdata_o;
        SelWb:   obs = bus.wb_data_o;
        default: obs = 32'(bus.wb_cnt_o);
      endcase
      check_eq(e.tag, obs, e.exp);
    end
  endtask

  task automatic drive(input logic r, input logic mtr, input logic we, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt);
    rst              = r;
    bus.MemtoReg_i   = mtr;
    bus.RegWrite_i   = we;
    bus.mem_data_i   = mem;
    bus.alu_result_i = alu;
    bus.RDaddr_i     = rd;
    bus.RSaddr_i     = rs;
    bus.RTaddr_i     = rt;
  endtask

  function automatic logic [31:0] m_wb();
    return bus.MemtoReg_i ? bus.mem_data_i : bus.alu_result_i;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (!rst || idx == 5'd0) return 32'h0;
    if (Bypass && bus.RegWrite_i && bus.RDaddr_i != 5'd0 && idx == bus.RDaddr_i) return m_wb();
    return m_rf[idx];
  endfunction

  // Compare mid-cycle, then advance one clock and update the model with what was committed.
  task automatic step();
    #3;
    drain();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_cnt = '0;
    end else if (bus.RegWrite_i && bus.RDaddr_i != 5'd0) begin
      m_rf[bus.RDaddr_i] = m_wb();
      m_cnt = m_cnt + 1'b1;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_cnt = '0;

    // Reset with a pending write to r5.
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'hDEAD, 5'd5, 5'd5, 5'd5);
    step();
    expect_out("rst_read_rs", SelRs, 32'h0);
    expect_out("rst_wb_mux", SelWb, 32'hDEAD);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
    expect_out("rst_r5_zero", SelRs, 32'h0);
    expect_out("rst_cnt_zero", SelCnt, 32'h0);
    step();

    // Mux selects memory data and writes r7.
    drive(1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 5'd7, 5'd0, 5'd0);
    expect_out("mux_mem", SelWb, 32'h1234_5678);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h5555_0000, 5'd0, 5'd7, 5'd7);
    expect_out("r7_read_rs", SelRs, 32'h1234_5678);
    expect_out("r7_read_rt", SelRt, 32'h1234_5678);
    expect_out("mux_alu", SelWb, 32'h5555_0000);
    expect_out("cnt_after_r7", SelCnt, 32'd1);
    step();

    // x0 write is discarded.
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'hAAAA_AAAA, 5'd0, 5'd0, 5'd0);
    expect_out("x0_rs_wcycle", SelRs, 32'h0);
    expect_out("x0_rt_wcycle", SelRt, 32'h0);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7);
    expect_out("x0_rs_after", SelRs, 32'h0);
    expect_out("x0_cnt_same", SelCnt, 32'd1);
    step();

    // Same-cycle RAW on r3.
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h11, 5'd3, 5'd0, 5'd0);
    step();
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h22, 5'd3, 5'd3, 5'd3);
    expect_out("raw_rs", SelRs, Bypass ? 32'h22 : 32'h11);
    expect_out("raw_rt", SelRt, Bypass ? 32'h22 : 32'h11);
    expect_out("raw_cnt", SelCnt, 32'd2);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    expect_out("raw_next_rs", SelRs, 32'h22);
    expect_out("raw_next_rt", SelRt, 32'h22);
    expect_out("raw_next_cnt", SelCnt, 32'd3);
    step();

    // Counter wrap: 12 more writes reach 15, one more wraps to 0.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h100 + 32'(i), 5'(8 + i), 5'd0, 5'd0);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd19);
    expect_out("cnt_max", SelCnt, 32'd15);
    expect_out("r8_read", SelRs, 32'h100);
    expect_out("r19_read", SelRt, 32'h10B);
    step();
    drive(1'b1, 1'b1, 1'b1, 32'h31, 32'h0, 5'd31, 5'd0, 5'd0);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd0);
    expect_out("cnt_wrap", SelCnt, 32'd0);
    expect_out("r31_read", SelRs, 32'h31);
    step();

    // Reset mid-stream during the r3 write.
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h1111, 5'd1, 5'd0, 5'd0);
    step();
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h2222, 5'd2, 5'd1, 5'd0);
    expect_out("mid_r1_pre", SelRs, 32'h1111);
    step();
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h3333, 5'd3, 5'd1, 5'd2);
    expect_out("mid_rst_rs", SelRs, 32'h0);
    expect_out("mid_rst_rt", SelRt, 32'h0);
    step();
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h4444, 5'd4, 5'd0, 5'd0);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2);
    expect_out("mid_r1_zero", SelRs, 32'h0);
    expect_out("mid_r2_zero", SelRt, 32'h0);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd4);
    expect_out("mid_r3_zero", SelRs, 32'h0);
    expect_out("mid_r4_kept", SelRt, 32'h4444);
    expect_out("mid_cnt", SelCnt, 32'd1);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd8);
    expect_out("mid_r31_cleared", SelRs, 32'h0);
    expect_out("mid_r8_cleared", SelRt, 32'h0);
    step();

    // Random stream checked against the model.
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom), $urandom, $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      expect_out("rnd_rs", SelRs, m_read(bus.RSaddr_i));
      expect_out("rnd_rt", SelRt, m_read(bus.RTaddr_i));
      expect_out("rnd_wb", SelWb, m_wb());
      expect_out("rnd_cnt", SelCnt, 32'(m_cnt));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
